// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: issues in-order imem requests under a credit limit and buffers
// returned words with their PCs in a prefetch FIFO; a redirect flushes and restarts fetch.
module fetch_prefetch_unit #(
  parameter int unsigned        BIN_DIG         = 32,
  parameter int unsigned        FIFO_DEPTH      = 4,
  parameter int unsigned        MAX_OUTSTANDING = 2,
  parameter logic [BIN_DIG-1:0] RESET_PC        = '0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               redirect,
  input  logic [BIN_DIG-1:0] redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [BIN_DIG-1:0] imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [BIN_DIG-1:0] imem_resp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BIN_DIG-1:0] curr_pc_reg,
  output logic [BIN_DIG-1:0] curr_inst
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [BIN_DIG-1:0] NopInst = BIN_DIG'(32'h13);
  localparam logic [BIN_DIG-1:0] PcStep  = BIN_DIG'(4);

  logic [BIN_DIG-1:0] fetch_pc_q, resp_pc_q;
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic [OW-1:0]      outstanding_q, drop_cnt_q;
  logic [BIN_DIG-1:0] fifo_pc_q   [FIFO_DEPTH];
  logic [BIN_DIG-1:0] fifo_inst_q [FIFO_DEPTH];

  logic [31:0] outs_ext, cnt_ext;
  logic        credit_ok, req_fire, resp_fire, drop_now, push, pop;
  logic [OW-1:0] outs_after_resp;

  always_comb begin
    outs_ext  = 32'(outstanding_q);
    cnt_ext   = 32'(count_q);
    // Credit covers both in-flight words and buffered words, so the FIFO can never overflow.
    credit_ok = (outs_ext < MAX_OUTSTANDING) && ((outs_ext + cnt_ext) < FIFO_DEPTH);
    imem_req_valid  = RST & ~redirect & credit_ok;
    imem_req_addr   = fetch_pc_q;
    req_fire        = imem_req_valid & imem_req_ready;
    resp_fire       = imem_resp_valid & (outstanding_q != '0);
    drop_now        = resp_fire & (drop_cnt_q != '0);
    push            = resp_fire & ~drop_now & ~redirect;
    out_valid       = (count_q != '0);
    pop             = out_valid & out_ready & ~redirect;
    outs_after_resp = outstanding_q - OW'(resp_fire);
    curr_pc_reg     = out_valid ? fifo_pc_q[rd_ptr_q] : '0;
    curr_inst       = out_valid ? fifo_inst_q[rd_ptr_q] : NopInst;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else if (redirect) begin
      fetch_pc_q    <= redirect_pc;
      resp_pc_q     <= redirect_pc;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      // Every word still in flight after this cycle belongs to the old stream.
      outstanding_q <= outs_after_resp;
      drop_cnt_q    <= outs_after_resp;
    end else begin
      if (req_fire) fetch_pc_q <= fetch_pc_q + PcStep;
      if (push) begin
        resp_pc_q <= resp_pc_q + PcStep;
        wr_ptr_q  <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q       <= count_q + CW'(push) - CW'(pop);
      outstanding_q <= outstanding_q + OW'(req_fire) - OW'(resp_fire);
      if (drop_now) drop_cnt_q <= drop_cnt_q - OW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
      fifo_inst_q[wr_ptr_q] <= imem_resp_data;
    end
  end

endmodule
